receive_engine: RTL and testbench

RECEIVE_ENGINE -- requirements
Module: receive_engine

---
 rtl/uart_pkg.sv | 25 ++
 rtl/rx_bit_timer.sv | 43 ++++
 rtl/receive_engine.sv | 161 ++++++++++++++++
 tb/tb_receive_engine.sv | 222 ++++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared definitions for the UART receive path.
//   BAUD_W     width of the bit-time (baud) value and bit-time counter
//   DATA_W     width of the received data word
//   FRAME_W    widest data+parity field captured from the line
//   rx_state_e receive state machine encoding
//   frame_bits number of serial bits between start and stop bits
package uart_pkg;

    localparam int BAUD_W  = 19;
    localparam int DATA_W  = 8;
    localparam int FRAME_W = 9;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_e;

    // 7 or 8 data bits, plus one parity bit when enabled.
    function automatic logic [3:0] frame_bits(input logic eight, input logic pen);
        return 4'd7 + {3'b000, eight} + {3'b000, pen};
    endfunction

endpackage

// File: rtl/rx_bit_timer.sv
// rx_bit_timer: bit-time counter for the UART receiver.
//   clk       system clock
//   reset     asynchronous active-high reset
//   clear     restart the count at 0 on the next edge
//   baud      bit time in clk cycles
//   half_hit  count has reached baud>>1 (centre of the start bit)
//   full_hit  count has reached baud-1 (one full bit time elapsed)
module rx_bit_timer
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              clear,
    input  logic [BAUD_W-1:0] baud,
    output logic              half_hit,
    output logic              full_hit
);

    logic [BAUD_W-1:0] count_q;
    logic [BAUD_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear) begin
            count_d = '0;
        end else if (count_q != {BAUD_W{1'b1}}) begin
            // Saturate rather than wrap so a stuck bit never aliases a hit.
            count_d = count_q + 1'b1;
        end
    end

    assign half_hit = (count_q == (baud >> 1));
    assign full_hit = (count_q == (baud - 1'b1));

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

endmodule

// File: rtl/receive_engine.sv
// receive_engine: UART receiver with 7/8 data bits, optional odd/even parity.
//   clk, reset   system clock, asynchronous active-high reset
//   RX           serial input (idle high, asynchronous to clk)
//   baud         bit time in clk cycles
//   EIGHT/PEN/OHEL  8-bit data / parity enable / odd parity select
//   read0        host strobe consuming the current frame
//   UART_RDATA   last received data word
//   RXRDY        frame available; PERR/FERR/OVF status of that frame
module receive_engine
    import uart_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              RX,
    input  logic [BAUD_W-1:0] baud,
    input  logic              EIGHT,
    input  logic              PEN,
    input  logic              OHEL,
    input  logic              read0,
    output logic [DATA_W-1:0] UART_RDATA,
    output logic              RXRDY,
    output logic              PERR,
    output logic              FERR,
    output logic              OVF
);

    rx_state_e          state_q, state_d;
    logic               rx_meta_q, rxs_q;
    logic [3:0]         bit_cnt_q, bit_cnt_d;
    logic [FRAME_W-1:0] frame_q, frame_d;
    logic [DATA_W-1:0]  rdata_q, rdata_d;
    logic               rxrdy_q, rxrdy_d;
    logic               perr_q, perr_d;
    logic               ferr_q, ferr_d;
    logic               ovf_q, ovf_d;

    logic               tmr_clear;
    logic               half_hit, full_hit;
    logic               frame_done;
    logic [3:0]         nbits;
    logic [DATA_W-1:0]  data_bits;
    logic               parity_bit;

    rx_bit_timer u_timer (
        .clk      (clk),
        .reset    (reset),
        .clear    (tmr_clear),
        .baud     (baud),
        .half_hit (half_hit),
        .full_hit (full_hit)
    );

    assign nbits = frame_bits(EIGHT, PEN);

    // Data sits at frame_q[6:0] / [7:0]; the parity bit follows the last data bit.
    assign data_bits  = {frame_q[7] & EIGHT, frame_q[6:0]};
    assign parity_bit = EIGHT ? frame_q[8] : frame_q[7];

    always_comb begin
        state_d    = state_q;
        bit_cnt_d  = bit_cnt_q;
        frame_d    = frame_q;
        rdata_d    = rdata_q;
        rxrdy_d    = rxrdy_q;
        perr_d     = perr_q;
        ferr_d     = ferr_q;
        ovf_d      = ovf_q;
        tmr_clear  = 1'b0;
        frame_done = 1'b0;

        case (state_q)
            ST_IDLE: begin
                tmr_clear = 1'b1;
                if (!rxs_q) begin
                    state_d = ST_START;
                end
            end
            ST_START: begin
                if (half_hit) begin
                    tmr_clear = 1'b1;
                    if (!rxs_q) begin
                        state_d   = ST_DATA;
                        bit_cnt_d = 4'd0;
                        frame_d   = '0;
                    end else begin
                        state_d = ST_IDLE;  // glitch, not a real start bit
                    end
                end
            end
            ST_DATA: begin
                if (full_hit) begin
                    tmr_clear          = 1'b1;
                    frame_d[bit_cnt_q] = rxs_q;
                    if (bit_cnt_q == nbits - 4'd1) begin
                        state_d = ST_STOP;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 4'd1;
                    end
                end
            end
            ST_STOP: begin
                if (full_hit) begin
                    tmr_clear  = 1'b1;
                    frame_done = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: begin
                tmr_clear = 1'b1;
                state_d   = ST_IDLE;
            end
        endcase

        // A completing frame wins over a simultaneous host read.
        if (frame_done) begin
            rdata_d = data_bits;
            rxrdy_d = 1'b1;
            perr_d  = PEN & (^data_bits ^ parity_bit ^ OHEL);
            ferr_d  = ~rxs_q;
            ovf_d   = rxrdy_q & ~read0;
        end else if (read0) begin
            rxrdy_d = 1'b0;
            perr_d  = 1'b0;
            ferr_d  = 1'b0;
            ovf_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            rx_meta_q <= 1'b1;
            rxs_q     <= 1'b1;
            bit_cnt_q <= 4'd0;
            frame_q   <= '0;
            rdata_q   <= '0;
            rxrdy_q   <= 1'b0;
            perr_q    <= 1'b0;
            ferr_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            rx_meta_q <= RX;
            rxs_q     <= rx_meta_q;
            bit_cnt_q <= bit_cnt_d;
            frame_q   <= frame_d;
            rdata_q   <= rdata_d;
            rxrdy_q   <= rxrdy_d;
            perr_q    <= perr_d;
            ferr_q    <= ferr_d;
            ovf_q     <= ovf_d;
        end
    end

    assign UART_RDATA = rdata_q;
    assign RXRDY      = rxrdy_q;
    assign PERR       = perr_q;
    assign FERR       = ferr_q;
    assign OVF        = ovf_q;

endmodule

// File: tb/tb_receive_engine.sv
// tb_receive_engine: directed, table-driven checks of receive_engine with a
// behavioural serial transmitter driving RX.
module tb_receive_engine;
    import uart_pkg::*;

    localparam int BAUD = 109;

    logic              clk;
    logic              reset;
    logic              RX;
    logic [BAUD_W-1:0] baud;
    logic              EIGHT, PEN, OHEL, read0;
    logic [DATA_W-1:0] UART_RDATA;
    logic              RXRDY, PERR, FERR, OVF;

    int tests;
    int failed;

    receive_engine dut (
        .clk        (clk),
        .reset      (reset),
        .RX         (RX),
        .baud       (baud),
        .EIGHT      (EIGHT),
        .PEN        (PEN),
        .OHEL       (OHEL),
        .read0      (read0),
        .UART_RDATA (UART_RDATA),
        .RXRDY      (RXRDY),
        .PERR       (PERR),
        .FERR       (FERR),
        .OVF        (OVF)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] tx_data;
        logic       eight;
        logic       pen;
        logic       ohel;
        logic       flip;      // invert the transmitted parity bit
        logic       stop;      // value driven during the stop bit
        logic [7:0] exp_data;
        logic       exp_perr;
        logic       exp_ferr;
    } vec_t;

    vec_t vecs[7];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Transmit one frame. With rd_at_done, read0 is pulsed so that it is high
    // at the very edge where the receiver samples the stop bit.
    task automatic send_frame(input logic [7:0] d, input logic eight, input logic pen,
                              input logic ohel, input logic flip, input logic stop,
                              input logic rd_at_done);
        logic [8:0] bits;
        logic       p;
        int         n;
        n    = 7 + int'(eight);
        bits = '0;
        p    = ohel ^ flip;
        for (int i = 0; i < n; i++) begin
            bits[i] = d[i];
            p       = p ^ d[i];
        end
        if (pen) begin
            bits[n] = p;
            n++;
        end
        EIGHT = eight;
        PEN   = pen;
        OHEL  = ohel;
        @(posedge clk);
        #1;
        RX = 1'b0;
        tick(BAUD);
        for (int i = 0; i < n; i++) begin
            RX = bits[i];
            tick(BAUD);
        end
        RX = stop;
        for (int j = 0; j < BAUD; j++) begin
            read0 = rd_at_done && (j == BAUD / 2 + 3);
            tick(1);
            read0 = 1'b0;
        end
        RX = 1'b1;
    endtask

    task automatic pulse_read();
        read0 = 1'b1;
        tick(1);
        read0 = 1'b0;
    endtask

    initial begin
        tests  = 0;
        failed = 0;
        reset  = 1'b1;
        RX     = 1'b1;
        baud   = 19'(BAUD);
        EIGHT  = 1'b1;
        PEN    = 1'b0;
        OHEL   = 1'b0;
        read0  = 1'b0;

        //            data   E     P     O     flip  stop  exp    perr  ferr
        vecs[0] = '{8'h07, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 8'h07, 1'b0, 1'b0};
        vecs[1] = '{8'h55, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 8'h55, 1'b1, 1'b0};
        vecs[2] = '{8'hA3, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'hA3, 1'b0, 1'b1};
        vecs[3] = '{8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};
        vecs[4] = '{8'h5A, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 8'h5A, 1'b0, 1'b0};
        vecs[5] = '{8'hC3, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 8'hC3, 1'b0, 1'b0};
        vecs[6] = '{8'hFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 8'h7F, 1'b0, 1'b0};

        tick(3);
        check("reset_rdata", 32'(UART_RDATA), 32'h00);
        check("reset_flags", {28'b0, RXRDY, PERR, FERR, OVF}, 32'h0);
        reset = 1'b0;
        tick(5);

        // Table-driven frames, each consumed by read0.
        for (int v = 0; v < 7; v++) begin
            send_frame(vecs[v].tx_data, vecs[v].eight, vecs[v].pen, vecs[v].ohel,
                       vecs[v].flip, vecs[v].stop, 1'b0);
            $display("[TB] vec %0d: tx 0x%02h -> rdata 0x%02h rxrdy %0b perr %0b ferr %0b ovf %0b",
                     v, vecs[v].tx_data, UART_RDATA, RXRDY, PERR, FERR, OVF);
            check("vec_rdata", 32'(UART_RDATA), 32'(vecs[v].exp_data));
            check("vec_rxrdy", 32'(RXRDY), 32'h1);
            check("vec_perr",  32'(PERR),  32'(vecs[v].exp_perr));
            check("vec_ferr",  32'(FERR),  32'(vecs[v].exp_ferr));
            check("vec_ovf",   32'(OVF),   32'h0);
            pulse_read();
            check("read_flags", {28'b0, RXRDY, PERR, FERR, OVF}, 32'h0);
            check("read_hold",  32'(UART_RDATA), 32'(vecs[v].exp_data));
            tick(2 * BAUD);
        end

        // False start: line low for 20 cycles only.
        @(posedge clk);
        #1;
        RX = 1'b0;
        tick(20);
        check("false_start_in_start", 32'(dut.state_q), 32'(ST_START));
        RX = 1'b1;
        tick(2 * BAUD);
        $display("[TB] false start: state %0d rxrdy %0b", dut.state_q, RXRDY);
        check("false_start_idle",  32'(dut.state_q), 32'(ST_IDLE));
        check("false_start_rxrdy", 32'(RXRDY), 32'h0);

        // Overflow: two frames without a read in between.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("[TB] overflow: rdata 0x%02h rxrdy %0b ovf %0b", UART_RDATA, RXRDY, OVF);
        check("ovf_set",   32'(OVF), 32'h1);
        check("ovf_rdata", 32'(UART_RDATA), 32'h22);
        check("ovf_rxrdy", 32'(RXRDY), 32'h1);
        pulse_read();
        check("ovf_cleared", {28'b0, RXRDY, PERR, FERR, OVF}, 32'h0);
        tick(BAUD);

        // read0 coinciding with completion: completion wins, no overflow.
        send_frame(8'h11, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
        $display("[TB] read at completion: rdata 0x%02h rxrdy %0b ovf %0b", UART_RDATA, RXRDY, OVF);
        check("prio_ovf",   32'(OVF), 32'h0);
        check("prio_rxrdy", 32'(RXRDY), 32'h1);
        check("prio_rdata", 32'(UART_RDATA), 32'h22);
        pulse_read();
        tick(BAUD);

        // 7-bit frame, then reset in the middle of the next one.
        send_frame(8'h7F, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("[TB] 7-bit frame: rdata 0x%02h rxrdy %0b", UART_RDATA, RXRDY);
        check("seven_rdata", 32'(UART_RDATA), 32'h7F);
        check("seven_rxrdy", 32'(RXRDY), 32'h1);
        @(posedge clk);
        #1;
        RX = 1'b0;
        tick(3 * BAUD);
        #2;
        reset = 1'b1;
        #1;
        $display("[TB] mid-frame reset: rdata 0x%02h flags %0b%0b%0b%0b",
                 UART_RDATA, RXRDY, PERR, FERR, OVF);
        check("rst_async_rdata", 32'(UART_RDATA), 32'h00);
        check("rst_async_flags", {28'b0, RXRDY, PERR, FERR, OVF}, 32'h0);
        check("rst_async_state", 32'(dut.state_q), 32'(ST_IDLE));
        RX = 1'b1;
        tick(3);
        reset = 1'b0;
        tick(2 * BAUD);
        check("post_rst_rdata", 32'(UART_RDATA), 32'h00);
        check("post_rst_flags", {28'b0, RXRDY, PERR, FERR, OVF}, 32'h0);

        // Receiver recovers after reset.
        send_frame(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        $display("[TB] post-reset frame: rdata 0x%02h rxrdy %0b", UART_RDATA, RXRDY);
        check("recover_rdata", 32'(UART_RDATA), 32'h3C);
        check("recover_rxrdy", 32'(RXRDY), 32'h1);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end

endmodule
